mem_bank_arbiter: RTL
=====================

// Module: mem_bank_arbiter
// PURPOSE
//  Shares one 256x8 data-memory bank (sync write, combinational read, MemWrite/MemRead) among NUM_REQ requesters.
//  Round-robin arbitration; the granted command is registered and driven onto the bank port for one cycle.
//  Read data is registered and returned with a one-hot valid.
//  Sits between the compute engines and each data-memory bank; one instance per bank.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  ADDR_W   8  address width; matches bank depth 256
//  DATA_W   8  data width; matches bank word
// PORTS
//  Clk          in   1                  single clock; all state on posedge Clk
//  Rst          in   1                  asynchronous, active-high reset
//  Req          in   NUM_REQ            per-requester request; hold until Gnt seen
//  ReqWr        in   NUM_REQ            1 = write, 0 = read; per requester
//  ReqAddr      in   NUM_REQ*ADDR_W     requester i at [i*ADDR_W +: ADDR_W]
//  ReqWData     in   NUM_REQ*DATA_W     requester i at [i*DATA_W +: DATA_W]
//  Gnt          out  NUM_REQ            one-hot, 1-cycle acceptance pulse
//  RData        out  DATA_W             registered read data (shared bus)
//  RValid       out  NUM_REQ            one-hot, 1-cycle pulse: RData belongs to requester i
//  MemAddress   out  ADDR_W             to bank Address
//  MemWriteData out  DATA_W             to bank WriteData
//  MemWrite     out  1                  to bank MemWrite
//  MemRead      out  1                  to bank MemRead
//  MemReadData  in   DATA_W             from bank ReadData (combinational)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; Gnt=0, RValid=0, RData=0, MemWrite=0, MemRead=0, MemAddress=0,
//    MemWriteData=0; rr pointer=0. Reset mid-ACCESS aborts the access; the in-flight write is not committed.
//  - FSM: IDLE, ACCESS.
//    IDLE: if any eligible Req, register winner -> ACCESS; else stay.
//    ACCESS: drive latched command; if another eligible Req exists, register next winner and stay in ACCESS;
//    else -> IDLE.
//  - Eligible: Req[i]=1 AND not (Gnt[i]=1 this cycle); a requester's Req is ignored in its own Gnt cycle.
//  - Arbitration: round-robin; search starts at pointer p, ascending index, wraps NUM_REQ-1 -> 0.
//    After granting i, p = (i+1) mod NUM_REQ.
//  - Latency:
//    Req sampled at edge E; command latched at E.
//    Cycle E..E+1: Gnt[i]=1; Mem* driven from latched cmd; MemWrite=ReqWr, MemRead=~ReqWr.
//    Write commits to the bank at edge E+1.
//    Read: MemReadData captured into RData at E+1; RValid[i]=1 for cycle E+1..E+2.
//  - Throughput: one access per cycle with continuous requests.
//    Read-after-write to the same address from back-to-back grants returns the new data.
//  - Outside ACCESS: MemWrite=MemRead=0; MemAddress and MemWriteData hold their last values.
//    RValid is 0 except the cycle after a read access.
//  - Requesters must keep Addr/WData/Wr stable while Req=1 and not granted.
//    Dropping Req before Gnt withdraws the request with no side effects.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds port ConflictCnt out 16.
//    Increments each cycle with >=2 eligible requests; saturates at 16'hFFFF; reset to 0.
//  MEM_ARB_STATS_EN undefined: port and counter absent; arbitration unchanged.
// TESTING
//  1) Rst pulse mid-ACCESS write (Req0, Wr, Addr 8'h10, WData 8'hAA) -> outputs 0 immediately;
//     mem[8'h10] unchanged; FSM in IDLE.
//  2) Req1 write Addr 8'h20 WData 8'h5A; then Req1 read 8'h20 -> Gnt[1] 1 cycle after each Req;
//     RValid[1] with RData=8'h5A 2 cycles after the read Req.
//  3) Req[3:0]=4'hF held continuously, p=0 -> Gnt sequence 1,2,4,8,1,... one grant per cycle; no gaps.
//  4) Req2 write 8'h33 to 8'h40, Req3 read 8'h40 same cycle -> Gnt[2] then Gnt[3] on consecutive cycles;
//     RData=8'h33.
//  5) Req0 asserted then dropped before grant while Req1 granted -> Gnt[0] never asserted;
//     no MemWrite/MemRead for requester 0.
//  6) MEM_ARB_STATS_EN: 4 requesters continuously requesting for 10 cycles -> ConflictCnt=10;
//     force 16'hFFFF, conflict -> stays 16'hFFFF.

Source files
------------

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing one data-memory bank among NUM_REQ requesters.
// Optional conflict counter (ConflictCnt port) is built when MEM_ARB_STATS_EN is defined.
module mem_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_REQ-1:0]          Req,
  input  logic [NUM_REQ-1:0]          ReqWr,
  input  logic [NUM_REQ*ADDR_W-1:0]   ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0]   ReqWData,
  output logic [NUM_REQ-1:0]          Gnt,
  output logic [DATA_W-1:0]           RData,
  output logic [NUM_REQ-1:0]          RValid,
  output logic [ADDR_W-1:0]           MemAddress,
  output logic [DATA_W-1:0]           MemWriteData,
  output logic                        MemWrite,
  output logic                        MemRead,
  input  logic [DATA_W-1:0]           MemReadData
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]                 ConflictCnt
`endif
);

  localparam int PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  rValid_q;
  logic [DATA_W-1:0]   rData_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [DATA_W-1:0]   memWData_q;
  logic                memWrite_q;
  logic                memRead_q;
  logic [PtrW-1:0]     ptr_q;

  logic [NUM_REQ-1:0]  eligible;
  logic                found;
  logic [NUM_REQ-1:0]  winGnt;
  logic                winWr;
  logic [ADDR_W-1:0]   winAddr;
  logic [DATA_W-1:0]   winWData;
  logic [PtrW-1:0]     winNextPtr;

  function automatic int rrIndex(input int base, input int offset);
    return (base + offset) % NUM_REQ;
  endfunction

  // A requester being granted this cycle cannot win again until its Gnt pulse ends.
  assign eligible = Req & ~gnt_q;

  always_comb begin
    found      = 1'b0;
    winGnt     = '0;
    winWr      = 1'b0;
    winAddr    = '0;
    winWData   = '0;
    winNextPtr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && eligible[rrIndex(int'(ptr_q), k)]) begin
        found                          = 1'b1;
        winGnt[rrIndex(int'(ptr_q), k)] = 1'b1;
        winWr      = ReqWr[rrIndex(int'(ptr_q), k)];
        winAddr    = ReqAddr[rrIndex(int'(ptr_q), k)*ADDR_W +: ADDR_W];
        winWData   = ReqWData[rrIndex(int'(ptr_q), k)*DATA_W +: DATA_W];
        winNextPtr = PtrW'(rrIndex(int'(ptr_q), k + 1));
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rValid_q   <= '0;
      rData_q    <= '0;
      memAddr_q  <= '0;
      memWData_q <= '0;
      memWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      ptr_q      <= '0;
    end else begin
      rValid_q <= '0;
      if (state_q == ACCESS && memRead_q) begin
        rData_q  <= MemReadData;
        rValid_q <= gnt_q;
      end
      // Address and write data keep their last values when the bank is idle.
      if (found) begin
        state_q    <= ACCESS;
        gnt_q      <= winGnt;
        memAddr_q  <= winAddr;
        memWData_q <= winWData;
        memWrite_q <= winWr;
        memRead_q  <= ~winWr;
        ptr_q      <= winNextPtr;
      end else begin
        state_q    <= IDLE;
        gnt_q      <= '0;
        memWrite_q <= 1'b0;
        memRead_q  <= 1'b0;
      end
    end
  end

  assign Gnt          = gnt_q;
  assign RValid       = rValid_q;
  assign RData        = rData_q;
  assign MemAddress   = memAddr_q;
  assign MemWriteData = memWData_q;
  assign MemWrite     = memWrite_q;
  assign MemRead      = memRead_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflictCnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      conflictCnt_q <= '0;
    end else if (($countones(eligible) >= 2) && (conflictCnt_q != 16'hFFFF)) begin
      conflictCnt_q <= conflictCnt_q + 16'd1;
    end
  end

  assign ConflictCnt = conflictCnt_q;
`endif

endmodule
